// File: rtl/my_pipe_mips32.sv
// my_pipe_mips32: 5-stage in-order MIPS-like pipeline over a unified word-addressed memory,
// with ALU forwarding, a one-cycle load-use stall, EX-stage branch resolution and HLT drain.
module my_pipe_mips32 #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic reset,
    output logic halted
);

    // state   | meaning
    // FS_RUN  | fetching one instruction per cycle
    // FS_STOP | HLT decoded; PC frozen, IF/ID fed bubbles until reset

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {K_NOP, K_RR, K_RI, K_LW, K_SW, K_BR, K_HLT} kind_e;
    typedef enum logic {FS_RUN, FS_STOP} fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        kind_e       kind;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  dest;
        logic [31:0] result;
    } mem_wb_t;

    function automatic logic writes_reg(kind_e k);
        return (k == K_RR) || (k == K_RI) || (k == K_LW);
    endfunction

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    fetch_state_e fetch_state_q, fetch_state_d;
    logic [31:0]  pc_d;
    if_id_t       if_id_q, if_id_d;
    id_ex_t       id_ex_q, id_ex_d;
    ex_mem_t      ex_mem_q, ex_mem_d;
    mem_wb_t      mem_wb_q, mem_wb_d;

    assign halted = HALTED;

    // ---------------- IF ----------------
    logic [AW-1:0] if_idx;
    logic [31:0]   if_ir;
    assign if_idx = AW'(PC % 32'(MEM_DEPTH));
    assign if_ir  = Mem[if_idx];

    // ---------------- ID ----------------
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_a, id_b;
    kind_e       id_kind;
    logic        id_uses_rs, id_uses_rt, load_use, wb_we;

    assign id_op  = if_id_q.ir[31:26];
    assign id_rs  = if_id_q.ir[25:21];
    assign id_rt  = if_id_q.ir[20:16];
    assign id_rd  = if_id_q.ir[15:11];
    assign id_imm = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};

    always_comb begin
        id_kind = K_NOP;
        if (if_id_q.valid) begin
            case (id_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_kind = K_RR;
                OP_ADDI, OP_SUBI, OP_SLTI:                     id_kind = K_RI;
                OP_LW:                                         id_kind = K_LW;
                OP_SW:                                         id_kind = K_SW;
                OP_BNEQZ, OP_BEQZ:                             id_kind = K_BR;
                OP_HLT:                                        id_kind = K_HLT;
                default:                                       id_kind = K_NOP;
            endcase
        end
    end

    assign wb_we = writes_reg(mem_wb_q.kind) && (mem_wb_q.dest != 5'd0) && !HALTED && !reset;

    // The WB write lands in the first half of the cycle, so ID sees it through this bypass.
    always_comb begin
        id_a = (id_rs == 5'd0) ? 32'd0 : Reg[id_rs];
        id_b = (id_rt == 5'd0) ? 32'd0 : Reg[id_rt];
        if (wb_we && (mem_wb_q.dest == id_rs)) id_a = mem_wb_q.result;
        if (wb_we && (mem_wb_q.dest == id_rt)) id_b = mem_wb_q.result;
    end

    assign id_uses_rs = id_kind inside {K_RR, K_RI, K_LW, K_SW, K_BR};
    assign id_uses_rt = id_kind inside {K_RR, K_SW};
    assign load_use   = (id_ex_q.kind == K_LW) && (id_ex_q.dest != 5'd0) &&
                        ((id_uses_rs && (id_rs == id_ex_q.dest)) ||
                         (id_uses_rt && (id_rt == id_ex_q.dest)));

    // ---------------- EX ----------------
    logic        fwd_em, fwd_mw, ex_taken;
    logic [31:0] ex_a, ex_b, ex_alu, ex_target;

    assign fwd_em = writes_reg(ex_mem_q.kind) && (ex_mem_q.kind != K_LW) && (ex_mem_q.dest != 5'd0);
    assign fwd_mw = writes_reg(mem_wb_q.kind) && (mem_wb_q.dest != 5'd0);

    always_comb begin
        ex_a = id_ex_q.a;
        ex_b = id_ex_q.b;
        if (fwd_mw && (mem_wb_q.dest == id_ex_q.rs)) ex_a = mem_wb_q.result;
        if (fwd_mw && (mem_wb_q.dest == id_ex_q.rt)) ex_b = mem_wb_q.result;
        if (fwd_em && (ex_mem_q.dest == id_ex_q.rs)) ex_a = ex_mem_q.alu;
        if (fwd_em && (ex_mem_q.dest == id_ex_q.rt)) ex_b = ex_mem_q.alu;
    end

    always_comb begin
        ex_alu = 32'd0;
        case (id_ex_q.op)
            OP_ADD:               ex_alu = ex_a + ex_b;
            OP_SUB:               ex_alu = ex_a - ex_b;
            OP_AND:               ex_alu = ex_a & ex_b;
            OP_OR:                ex_alu = ex_a | ex_b;
            OP_SLT:               ex_alu = ($signed(ex_a) < $signed(ex_b)) ? 32'd1 : 32'd0;
            OP_MUL:               ex_alu = ex_a * ex_b;
            OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + id_ex_q.imm;
            OP_SUBI:              ex_alu = ex_a - id_ex_q.imm;
            OP_SLTI:              ex_alu = ($signed(ex_a) < $signed(id_ex_q.imm)) ? 32'd1 : 32'd0;
            default:              ex_alu = 32'd0;
        endcase
    end

    assign ex_target = id_ex_q.npc + id_ex_q.imm;
    assign ex_taken  = (id_ex_q.kind == K_BR) &&
                       ((id_ex_q.op == OP_BNEQZ) ? (ex_a != 32'd0) : (ex_a == 32'd0));

    // ---------------- MEM ----------------
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    assign mem_idx   = AW'(ex_mem_q.alu % 32'(MEM_DEPTH));
    assign mem_rdata = Mem[mem_idx];
    assign mem_we    = (ex_mem_q.kind == K_SW) && !HALTED && !reset;

    // ---------------- next state ----------------
    always_comb begin
        pc_d          = PC;
        fetch_state_d = fetch_state_q;
        if_id_d       = if_id_q;
        id_ex_d       = '{kind: id_kind, op: id_op, rs: id_rs, rt: id_rt,
                          dest: (id_kind == K_RR) ? id_rd : id_rt,
                          a: id_a, b: id_b, imm: id_imm, npc: if_id_q.npc};
        ex_mem_d      = '{kind: id_ex_q.kind, dest: id_ex_q.dest, alu: ex_alu, sdata: ex_b};
        mem_wb_d      = '{kind: ex_mem_q.kind, dest: ex_mem_q.dest,
                          result: (ex_mem_q.kind == K_LW) ? mem_rdata : ex_mem_q.alu};

        // A taken branch outranks both the load-use stall and an HLT sitting in ID.
        if (ex_taken) begin
            pc_d    = ex_target;
            if_id_d = '0;
            id_ex_d = '0;
        end else if (load_use) begin
            id_ex_d = '0;
        end else if (id_kind == K_HLT) begin
            fetch_state_d = FS_STOP;
            if_id_d       = '0;
        end else if (fetch_state_q == FS_STOP) begin
            if_id_d = '0;
        end else begin
            if_id_d = '{valid: 1'b1, ir: if_ir, npc: PC + 32'd1};
            pc_d    = PC + 32'd1;
        end

        if (HALTED) pc_d = PC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC            <= 32'd0;
            HALTED        <= 1'b0;
            TAKEN_BRANCH  <= 1'b0;
            fetch_state_q <= FS_RUN;
            if_id_q       <= '0;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
        end else begin
            PC            <= pc_d;
            HALTED        <= HALTED | (mem_wb_q.kind == K_HLT);
            TAKEN_BRANCH  <= ex_taken;
            fetch_state_q <= fetch_state_d;
            if_id_q       <= if_id_d;
            id_ex_q       <= id_ex_d;
            ex_mem_q      <= ex_mem_d;
            mem_wb_q      <= mem_wb_d;
        end
    end

    // Architectural storage is not cleared by reset.
    always_ff @(posedge clk) begin
        if (wb_we)  Reg[mem_wb_q.dest] <= mem_wb_q.result;
        if (mem_we) Mem[mem_idx]       <= ex_mem_q.sdata;
    end

endmodule

// File: tb/tb_my_pipe_mips32.sv
// tb_my_pipe_mips32: directed programs plus random programs checked against an
// instruction-level interpreter of the ISA.
module tb_my_pipe_mips32;

    localparam int DEPTH = 1024;
    localparam logic [31:0] HLT_W = 32'hFC00_0000;
    localparam logic [5:0] ADD = 6'h00, ADDI = 6'h0A, LW = 6'h08, SW = 6'h09, BEQZ = 6'h0E;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halted;

    my_pipe_mips32 #(.MEM_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .halted(halted));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:DEPTH-1];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // ISA-level interpreter: runs m_mem from address 0 until HLT.
    task automatic run_model(output int hlt_pc);
        int unsigned pc;
        logic [31:0] ir, a, b, simm, nxt, res;
        logic [5:0]  op;
        int          rt, rd;
        pc = 0;
        hlt_pc = -1;
        for (int step = 0; step < 5000; step++) begin
            ir   = m_mem[pc % DEPTH];
            op   = ir[31:26];
            rt   = int'(ir[20:16]);
            rd   = int'(ir[15:11]);
            a    = (ir[25:21] == 5'd0) ? 32'd0 : m_reg[ir[25:21]];
            b    = (ir[20:16] == 5'd0) ? 32'd0 : m_reg[ir[20:16]];
            simm = {{16{ir[15]}}, ir[15:0]};
            nxt  = pc + 1;
            if (op == 6'h3F) begin
                hlt_pc = int'(pc);
                return;
            end
            if (op <= 6'h05) begin
                case (op)
                    6'h00: res = a + b;
                    6'h01: res = a - b;
                    6'h02: res = a & b;
                    6'h03: res = a | b;
                    6'h04: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: res = a * b;
                endcase
                if (rd != 0) m_reg[rd] = res;
            end else if (op >= 6'h0A && op <= 6'h0C) begin
                if (op == 6'h0A)      res = a + simm;
                else if (op == 6'h0B) res = a - simm;
                else                  res = ($signed(a) < $signed(simm)) ? 1 : 0;
                if (rt != 0) m_reg[rt] = res;
            end else if (op == 6'h08) begin
                if (rt != 0) m_reg[rt] = m_mem[(a + simm) % DEPTH];
            end else if (op == 6'h09) begin
                m_mem[(a + simm) % DEPTH] = b;
            end else if ((op == 6'h0D && a != 0) || (op == 6'h0E && a == 0)) begin
                nxt = pc + 1 + simm;
            end
            pc = nxt;
        end
    endtask

    task automatic preload_std();
        for (int k = 0; k < 32; k++) m_reg[k] = 32'(k + 7);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    endtask

    task automatic load_dut_and_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) dut.Mem[i] = m_mem[i];
        for (int k = 0; k < 32; k++) dut.Reg[k] = m_reg[k];
        @(negedge clk);
        check_val("rst_pc", dut.PC, 32'd0);
        check_val("rst_halted_int", 32'(dut.HALTED), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int max_cyc, output int cyc, output int taken);
        cyc = 0;
        taken = 0;
        while (halted !== 1'b1 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (dut.TAKEN_BRANCH === 1'b1) taken++;
        end
        check_val("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic gen_random(input int len);
        int sel;
        for (int k = 0; k < 31; k++) m_reg[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        m_reg[0]  = $urandom | 32'd1;
        m_reg[31] = 32'd512;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        for (int i = 512; i < 576; i++) m_mem[i] = $urandom;
        for (int i = 0; i < len; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: m_mem[i] = enc_r(6'($urandom_range(0, 5)), int'($urandom_range(0, 31)),
                                             int'($urandom_range(0, 31)), int'($urandom_range(0, 30)));
                4, 5: m_mem[i] = enc_i(6'(10 + $urandom_range(0, 2)), int'($urandom_range(0, 31)),
                                       int'($urandom_range(0, 30)), int'($urandom_range(0, 65535)));
                6: m_mem[i] = enc_i(LW, 31, int'($urandom_range(0, 30)), int'($urandom_range(0, 63)));
                7: m_mem[i] = enc_i(SW, 31, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
                8: m_mem[i] = enc_i(6'(13 + $urandom_range(0, 1)), int'($urandom_range(0, 30)), 0,
                                    int'($urandom_range(0, len - 1 - i)));
                default: m_mem[i] = enc_i(6'(32 + $urandom_range(0, 30)), int'($urandom_range(0, 31)),
                                          int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
            endcase
        end
        m_mem[len]     = HLT_W;
        m_mem[len + 1] = enc_i(ADDI, 0, 1, 77);
        m_mem[len + 2] = enc_r(ADD, 1, 1, 2);
    endtask

    int cyc, taken, hpc;

    initial begin
        repeat (2) @(negedge clk);

        // basic program
        preload_std();
        m_mem[0] = 32'h28010003; m_mem[1] = 32'h28020004; m_mem[2] = 32'h28030005;
        m_mem[3] = 32'h00221800; m_mem[4] = 32'h00632000; m_mem[5] = HLT_W;
        load_dut_and_reset();
        run_to_halt(15, cyc, taken);
        check_val("basic_cyc_le15", 32'(cyc <= 15), 32'd1);
        check_val("basic_r1", dut.Reg[1], 32'd3);
        check_val("basic_r2", dut.Reg[2], 32'd4);
        check_val("basic_r3", dut.Reg[3], 32'd7);
        check_val("basic_r4", dut.Reg[4], 32'd14);
        check_val("basic_taken", 32'(taken), 32'd0);

        // load-use stall
        preload_std();
        m_mem[120] = 32'd85;
        m_mem[0] = enc_i(ADDI, 0, 1, 120); m_mem[1] = enc_i(LW, 1, 2, 0);
        m_mem[2] = enc_i(ADDI, 2, 2, 45);  m_mem[3] = enc_i(SW, 1, 2, 1);
        m_mem[4] = HLT_W;
        load_dut_and_reset();
        run_to_halt(40, cyc, taken);
        check_val("ldu_mem121", dut.Mem[121], 32'd130);
        check_val("ldu_r2", dut.Reg[2], 32'd130);

        // taken-branch squash
        preload_std();
        m_mem[0] = enc_i(ADDI, 0, 1, 0); m_mem[1] = enc_i(BEQZ, 1, 0, 2);
        m_mem[2] = enc_i(ADDI, 0, 2, 9); m_mem[3] = enc_i(ADDI, 0, 3, 9);
        m_mem[4] = enc_i(ADDI, 0, 4, 1); m_mem[5] = HLT_W;
        load_dut_and_reset();
        run_to_halt(40, cyc, taken);
        check_val("br_r2", dut.Reg[2], 32'd9);
        check_val("br_r3", dut.Reg[3], 32'd10);
        check_val("br_r4", dut.Reg[4], 32'd1);
        check_val("br_taken_cycles", 32'(taken), 32'd1);

        // register 0 write discarded
        preload_std();
        m_mem[0] = enc_i(ADDI, 0, 0, 5); m_mem[1] = enc_r(ADD, 0, 0, 5); m_mem[2] = HLT_W;
        load_dut_and_reset();
        run_to_halt(40, cyc, taken);
        check_val("r0_r5", dut.Reg[5], 32'd0);
        check_val("r0_store", dut.Reg[0], 32'd7);

        // branch in EX beats HLT in ID
        preload_std();
        m_mem[0] = enc_i(BEQZ, 0, 0, 1); m_mem[1] = HLT_W;
        m_mem[2] = enc_i(ADDI, 0, 6, 6); m_mem[3] = HLT_W;
        load_dut_and_reset();
        run_to_halt(40, cyc, taken);
        check_val("brhlt_r6", dut.Reg[6], 32'd6);

        // post-halt: code after HLT never runs, PC stays put
        preload_std();
        m_mem[0] = enc_i(ADDI, 0, 1, 1); m_mem[1] = HLT_W;
        m_mem[2] = enc_i(ADDI, 0, 2, 2); m_mem[3] = enc_i(ADDI, 0, 3, 3);
        load_dut_and_reset();
        run_to_halt(40, cyc, taken);
        repeat (10) @(negedge clk);
        check_val("post_pc", dut.PC, 32'd2);
        check_val("post_halted", 32'(halted), 32'd1);
        check_val("post_r1", dut.Reg[1], 32'd1);
        check_val("post_r2", dut.Reg[2], 32'd9);
        check_val("post_r3", dut.Reg[3], 32'd10);

        // mid-run reset
        preload_std();
        m_mem[0] = 32'h28010003; m_mem[1] = 32'h28020004; m_mem[2] = 32'h28030005;
        m_mem[3] = 32'h00221800; m_mem[4] = 32'h00632000; m_mem[5] = HLT_W;
        load_dut_and_reset();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_pc", dut.PC, 32'd0);
        check_val("mid_halted", 32'(dut.HALTED), 32'd0);
        reset = 1'b0;
        run_to_halt(30, cyc, taken);
        check_val("mid_r1", dut.Reg[1], 32'd3);
        check_val("mid_r2", dut.Reg[2], 32'd4);
        check_val("mid_r3", dut.Reg[3], 32'd7);
        check_val("mid_r4", dut.Reg[4], 32'd14);

        // random programs vs interpreter
        for (int p = 0; p < 8; p++) begin
            gen_random(24);
            load_dut_and_reset();
            run_model(hpc);
            run_to_halt(400, cyc, taken);
            repeat (10) @(negedge clk);
            check_val($sformatf("rnd%0d_pc", p), dut.PC, 32'(hpc + 1));
            for (int k = 0; k < 32; k++)
                check_val($sformatf("rnd%0d_reg%0d", p, k), dut.Reg[k], m_reg[k]);
            for (int i = 0; i < DEPTH; i++)
                check_val($sformatf("rnd%0d_mem%0d", p, i), dut.Mem[i], m_mem[i]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
